decoder_pipe: RTL and testbench
===============================

DECODER_PIPE -- requirements
Module: decoder_pipe

Interface
REQ-001 Parameter: IN_WIDTH, default 4, width of the binary index input.
REQ-002 Parameter: OUT_WIDTH, default 16, number of decoded output lines; legal range 2..2**IN_WIDTH.
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: binary_in  input  IN_WIDTH  index to decode.
REQ-006 Port: enable  input  1  1 = decode the index; 0 = produce an all-zero word.
REQ-007 Port: mode  input  1  0 = one-hot; 1 = thermometer.
REQ-008 Port: in_valid  input  1  upstream presents binary_in/enable/mode.
REQ-009 Port: in_ready  output  1  block can accept; a transfer occurs when in_valid && in_ready at a clock edge.
REQ-010 Port: decoder_out  output  OUT_WIDTH  decoded word for the head entry.
REQ-011 Port: range_err  output  1  head entry had enable=1 and binary_in >= OUT_WIDTH.
REQ-012 Port: out_valid  output  1  decoder_out/range_err hold a valid entry.
REQ-013 Port: out_ready  input  1  downstream accepts; a pop occurs when out_valid && out_ready at a clock edge.

Function
REQ-014 Decode is computed at accept time; the decoded word, not the index, is stored in a 2-entry FIFO (skid buffer).
REQ-015 One-hot (mode=0): bit binary_in = 1, all other bits = 0.
REQ-016 Thermometer (mode=1): bits [binary_in:0] = 1, higher bits = 0.
REQ-017 enable=0: word all zeros, range_err=0, independent of binary_in and mode.
REQ-018 enable=1 with binary_in >= OUT_WIDTH: word all zeros, range_err=1, in both modes.
REQ-019 Latency: an entry accepted into an empty block appears with out_valid=1 on the cycle after the accepting edge.
REQ-020 in_ready = 1 when the FIFO holds fewer than 2 entries; it is driven from a register, with no combinational path from out_ready.
REQ-021 Entries leave in acceptance order; none is dropped or duplicated.
REQ-022 While out_valid=1 and out_ready=0, decoder_out and range_err stay stable.
REQ-023 Push and pop on the same edge with 1 entry held: count stays 1; the head becomes the new entry.
REQ-024 Full (2 entries): in_ready=0, so no push; a pop makes in_ready 1 on the following cycle.
REQ-025 Empty: out_valid=0 and decoder_out = 0; a pop is impossible.
REQ-026 Sustained throughput is 1 entry/cycle when out_ready is held high.

Reset
REQ-027 While rst_n=0 at a clock edge: FIFO emptied, out_valid=0, in_ready=0, decoder_out=0, range_err=0.
REQ-028 in_ready rises on the first edge with rst_n=1; transfers presented during reset are discarded.
REQ-029 Reset asserted mid-operation discards all held entries without emitting them.

Structure
REQ-030 Shared package decoder_pkg holds: mode encodings (MODE_ONEHOT=0, MODE_THERM=1), FIFO depth constant (2), and the default IN_WIDTH/OUT_WIDTH.
REQ-031 The combinational index-to-word function is one sub-module, decoder_core (binary_in, enable, mode -> word, err); decoder_pipe adds the FIFO and handshake only.

Verification (defaults IN_WIDTH=4, OUT_WIDTH=16 unless stated)
REQ-032 One-hot sweep: out_ready=1, push binary_in 0..15 with enable=1, mode=0 -> outputs 0x0001, 0x0002 ... 0x8000 in order, one per cycle, first output 1 cycle after first accept.
REQ-033 Thermometer and enable: push (5, mode=1), (15, mode=1), (15, enable=0) -> outputs 0x003F, 0xFFFF, 0x0000, with range_err=0 throughout.
REQ-034 Range error, OUT_WIDTH=10: push 9 then 12, enable=1 -> outputs 0x200 (err=0), then 0x000 (err=1).
REQ-035 Backpressure: out_ready=0, push 3, 7, 9 back-to-back -> in_ready=0 after the second accept and 9 is not taken; raise out_ready -> outputs 0x0008, 0x0080, then 0x0200, with decoder_out stable while stalled.
REQ-036 Reset mid-flight: 2 entries held, pulse rst_n=0 for one edge -> out_valid=0, decoder_out=0, in_ready=0; on the next edge in_ready=1; no old entry ever appears.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared definitions for the decoder pipeline.
//   mode_e            : decode style selected by the 'mode' input
//   FIFO_DEPTH        : number of decoded words the output buffer can hold
//   DEFAULT_IN_WIDTH  : default width of the binary index
//   DEFAULT_OUT_WIDTH : default number of decoded output lines
package decoder_pkg;

    typedef enum logic {
        MODE_ONEHOT = 1'b0,
        MODE_THERM  = 1'b1
    } mode_e;

    localparam int FIFO_DEPTH        = 2;
    localparam int DEFAULT_IN_WIDTH  = 4;
    localparam int DEFAULT_OUT_WIDTH = 16;

endpackage

// File: rtl/decoder_core.sv
// Combinational index-to-word decoder.
//   binary_in : index to decode
//   enable    : 0 forces an all-zero word with no error
//   mode      : MODE_ONEHOT or MODE_THERM
//   word      : decoded word (all zeros when disabled or out of range)
//   err       : index is out of range while enabled
module decoder_core
    import decoder_pkg::*;
#(
    parameter int IN_WIDTH  = DEFAULT_IN_WIDTH,
    parameter int OUT_WIDTH = DEFAULT_OUT_WIDTH
) (
    input  logic [IN_WIDTH-1:0]  binary_in,
    input  logic                 enable,
    input  logic                 mode,
    output logic [OUT_WIDTH-1:0] word,
    output logic                 err
);

    logic [31:0] idx;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else leaves a value held and infers a latch.
    always_comb begin
        idx  = 32'(binary_in);
        word = '0;
        err  = 1'b0;
        if (enable) begin
            if (idx >= 32'(OUT_WIDTH)) begin
                err = 1'b1;
            end else begin
                for (int i = 0; i < OUT_WIDTH; i++) begin
                    word[i] = (mode == MODE_THERM) ? (32'(i) <= idx) : (32'(i) == idx);
                end
            end
        end
    end

endmodule

// File: rtl/decoder_pipe.sv
// Decoder with a 2-entry output skid buffer and valid/ready handshakes.
// The index is decoded as it is accepted; the buffer stores decoded words.
//   clk, rst_n         : clock, synchronous active-low reset
//   binary_in, enable,
//   mode, in_valid     : upstream request
//   in_ready           : registered; high while the buffer has a free slot
//   decoder_out,
//   range_err,
//   out_valid          : head entry of the buffer (zeros when empty)
//   out_ready          : downstream accepts the head entry
module decoder_pipe
    import decoder_pkg::*;
#(
    parameter int IN_WIDTH  = DEFAULT_IN_WIDTH,
    parameter int OUT_WIDTH = DEFAULT_OUT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  binary_in,
    input  logic                 enable,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] decoder_out,
    output logic                 range_err,
    output logic                 out_valid,
    input  logic                 out_ready
);

    typedef struct packed {
        logic                 err;
        logic [OUT_WIDTH-1:0] word;
    } entry_t;

    logic [OUT_WIDTH-1:0] core_word;
    logic                 core_err;

    entry_t     mem_q [FIFO_DEPTH];
    entry_t     mem_d [FIFO_DEPTH];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       in_ready_q, in_ready_d;
    logic       push, pop;

    decoder_core #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_core (
        .binary_in (binary_in),
        .enable    (enable),
        .mode      (mode),
        .word      (core_word),
        .err       (core_err)
    );

    assign push = in_valid && in_ready_q;
    assign pop  = (count_q != 2'd0) && out_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{err: core_err, word: core_word};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
        // Ready is precomputed from the next occupancy so it leaves a flop
        // and never depends combinationally on out_ready.
        in_ready_d = (count_d < 2'(FIFO_DEPTH));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            in_ready_q <= in_ready_d;
        end
    end

    // NOTE: the storage array is not reset; a slot is only observable while
    // count_q covers it, and the outputs are forced to zero when empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (count_q != 2'd0);
    assign decoder_out = out_valid ? mem_q[rd_ptr_q].word : '0;
    assign range_err   = out_valid ? mem_q[rd_ptr_q].err  : 1'b0;

endmodule

// File: tb/tb_decoder_pipe.sv
// Bench for decoder_pipe: two instances (OUT_WIDTH 16 and 10) share one
// input stream; a queue-based reference model predicts both output streams.
module tb_decoder_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] binary_in = '0;
    logic       enable = 1'b0;
    logic       mode = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic        in_ready_a, range_err_a, out_valid_a;
    logic [15:0] decoder_out_a;
    logic        in_ready_b, range_err_b, out_valid_b;
    logic [9:0]  decoder_out_b;

    always #5 clk = ~clk;

    decoder_pipe #(.IN_WIDTH(4), .OUT_WIDTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .binary_in(binary_in), .enable(enable),
        .mode(mode), .in_valid(in_valid), .in_ready(in_ready_a),
        .decoder_out(decoder_out_a), .range_err(range_err_a),
        .out_valid(out_valid_a), .out_ready(out_ready)
    );

    decoder_pipe #(.IN_WIDTH(4), .OUT_WIDTH(10)) dut_b (
        .clk(clk), .rst_n(rst_n), .binary_in(binary_in), .enable(enable),
        .mode(mode), .in_valid(in_valid), .in_ready(in_ready_b),
        .decoder_out(decoder_out_b), .range_err(range_err_b),
        .out_valid(out_valid_b), .out_ready(out_ready)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    string phase = "reset";

    // Model state: FIFO contents as {err, word} and the registered ready.
    logic [16:0] mq_a[$];
    logic [16:0] mq_b[$];
    bit          m_ready = 1'b0;
    bit          accepted = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s [%s] got %0h expected %0h at %0t", tag, phase, got, exp, $time);
        end
    endtask

    // Decode from the rules: one-hot is 2^idx, thermometer is 2^(idx+1)-1.
    function automatic logic [16:0] ref_entry(int idx, bit en, bit md, int width);
        longint word = 0;
        bit     err  = 1'b0;
        if (en) begin
            if (idx >= width) err = 1'b1;
            else if (md)      word = (longint'(1) << (idx + 1)) - 1;
            else              word = longint'(1) << idx;
        end
        return {err, 16'(word)};
    endfunction

    task automatic compare_outputs();
        logic [16:0] ha, hb;
        ha = (mq_a.size() != 0) ? mq_a[0] : 17'd0;
        hb = (mq_b.size() != 0) ? mq_b[0] : 17'd0;
        check("out_valid_16", 32'(out_valid_a), 32'(mq_a.size() != 0));
        check("decoder_out_16", 32'(decoder_out_a), 32'(ha[15:0]));
        check("range_err_16", 32'(range_err_a), 32'(ha[16]));
        check("in_ready_16", 32'(in_ready_a), 32'(m_ready));
        check("out_valid_10", 32'(out_valid_b), 32'(mq_b.size() != 0));
        check("decoder_out_10", 32'(decoder_out_b), 32'(hb[9:0]));
        check("range_err_10", 32'(range_err_b), 32'(hb[16]));
        check("in_ready_10", 32'(in_ready_b), 32'(m_ready));
    endtask

    // One clock: compare at the falling edge, then advance the model with
    // the handshake seen at the rising edge. Inputs may change afterwards.
    task automatic cycle();
        bit do_push, do_pop;
        @(negedge clk);
        compare_outputs();
        do_push = in_valid && m_ready;
        do_pop  = (mq_a.size() != 0) && out_ready;
        @(posedge clk);
        if (!rst_n) begin
            mq_a.delete();
            mq_b.delete();
            m_ready  = 1'b0;
            accepted = 1'b0;
        end else begin
            if (do_pop) begin
                void'(mq_a.pop_front());
                void'(mq_b.pop_front());
            end
            if (do_push) begin
                mq_a.push_back(ref_entry(int'(binary_in), enable, mode, 16));
                mq_b.push_back(ref_entry(int'(binary_in), enable, mode, 10));
            end
            m_ready  = (mq_a.size() < 2);
            accepted = do_push;
        end
        #1;
    endtask

    // Present one request and hold it until accepted, with a cycle budget.
    task automatic offer(int idx, bit en, bit md);
        int budget = 20;
        in_valid  = 1'b1;
        binary_in = 4'(idx);
        enable    = en;
        mode      = md;
        do begin
            cycle();
            budget--;
        end while (!accepted && budget > 0);
        check("accept_timeout", 32'(accepted), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        // Reset with a request pending: it must be discarded.
        rst_n = 1'b0; in_valid = 1'b1; binary_in = 4'd3; enable = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        rst_n = 1'b1; in_valid = 1'b0;
        idle(2);

        phase = "onehot_sweep";
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) offer(i, 1'b1, 1'b0);
        idle(3);

        phase = "therm_enable";
        offer(5, 1'b1, 1'b1);
        offer(15, 1'b1, 1'b1);
        offer(15, 1'b0, 1'b1);
        idle(3);

        phase = "range_err";
        offer(9, 1'b1, 1'b0);
        offer(12, 1'b1, 1'b0);
        offer(10, 1'b1, 1'b1);
        idle(3);

        phase = "backpressure";
        out_ready = 1'b0;
        offer(3, 1'b1, 1'b0);
        offer(7, 1'b1, 1'b0);
        in_valid = 1'b1; binary_in = 4'd9; enable = 1'b1; mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("full_no_accept", 32'(accepted), 32'd0);
            check("full_in_ready", 32'(in_ready_a), 32'd0);
            check("stall_stable", 32'(decoder_out_a), 32'h0008);
        end
        out_ready = 1'b1;
        offer(9, 1'b1, 1'b0);
        idle(4);

        phase = "reset_midflight";
        out_ready = 1'b0;
        offer(1, 1'b1, 1'b0);
        offer(2, 1'b1, 1'b1);
        idle(1);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(1);
        check("post_reset_valid", 32'(out_valid_a), 32'd0);
        idle(3);

        phase = "random";
        for (int i = 0; i < 600; i++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            binary_in = 4'($urandom_range(0, 15));
            enable    = $urandom_range(0, 3) != 0;
            mode      = 1'($urandom);
            cycle();
        end
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
